// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the asynchronous program ROM.
// Owns the program counter, fetches one 35-bit word per cycle into a
// single registered buffer handed to decode over valid/ready, redirects
// on execute jumps, and shares the ROM port with a debug reader that is
// protected from starvation by a wait counter.
module fetch_sequencer #(
  parameter logic [7:0]  RESET_PC     = 8'd0,
  parameter logic [7:0]  PC_STEP      = 8'd4,
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  output logic [7:0]  rom_addr,
  input  logic [34:0] rom_data,
  output logic [34:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump_valid,
  input  logic [7:0]  jump_target,
  input  logic        dbg_req,
  input  logic [7:0]  dbg_addr,
  output logic [34:0] dbg_data,
  output logic        dbg_ack,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(DBG_MAX_WAIT);

  state_t      cur_state;
  logic [7:0]  pc;
  logic [3:0]  wait_cnt;

  logic        buf_free;
  logic        jump_take;
  logic        fetch_slot;
  logic        dbg_want;
  logic        forced_yield;
  logic        fetch;
  logic        dbg_grant;

  // The buffer can take a new word if it is empty or being drained now.
  assign buf_free     = !instr_valid || instr_ready;
  // Jumps are only honoured once the sequencer has been started.
  assign jump_take    = jump_valid && (cur_state != S_IDLE);
  // A cycle in which fetch would normally own the ROM port.
  assign fetch_slot   = (cur_state == S_RUN) && !halt && !jump_valid && buf_free;
  // One grant per request: the ack cycle never grants again.
  assign dbg_want     = dbg_req && !dbg_ack;
  // A starved debug request steals exactly one fetch slot.
  assign forced_yield = fetch_slot && dbg_want && (wait_cnt == WAIT_LIMIT);
  assign fetch        = fetch_slot && !forced_yield;
  // Debug gets the port whenever fetch is not using it.
  assign dbg_grant    = dbg_want && !fetch;

  assign rom_addr = dbg_grant ? dbg_addr : pc;
  assign state    = cur_state;

  // Sequencer state, program counter, instruction buffer and debug port.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see the same
    // pre-edge values, regardless of statement order.
    if (!rst_n) begin
      cur_state   <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      dbg_data    <= '0;
      dbg_ack     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      unique case (cur_state)
        S_IDLE:  if (start) cur_state <= S_RUN;
        S_RUN:   if (halt)  cur_state <= S_HALT;
        S_HALT:  if (!halt) cur_state <= S_RUN;
        default: cur_state <= S_IDLE;
      endcase

      // A jump flushes the buffer even if decode took the word this cycle.
      if (jump_take) begin
        pc          <= jump_target;
        instr_valid <= 1'b0;
      end else if (fetch) begin
        instr       <= rom_data;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + PC_STEP;
      end else if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end

      dbg_ack <= dbg_grant;
      if (dbg_grant) dbg_data <= rom_data;

      // Counts consecutive ungranted request cycles; saturates at 15.
      if (dbg_grant || !dbg_req) begin
        wait_cnt <= '0;
      end else if (wait_cnt != 4'hF) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with
// hand-derived cycle expectations plus a randomized run checked against
// a program-order / debug-read reference model.
module tb_fetch_sequencer;

  localparam logic [34:0] W_MOV = 35'h0_1000_0001;
  localparam logic [34:0] W_ACC = 35'h2_2000_000F;
  localparam logic [34:0] W_JMP = 35'h4_3000_0004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, halt, instr_ready, jump_valid, dbg_req;
  logic [7:0]  jump_target, dbg_addr;

  logic [7:0]  rom_addr, instr_pc;
  logic [34:0] rom_data, instr, dbg_data;
  logic        instr_valid, dbg_ack;
  logic [1:0]  state;

  logic [7:0]  rom_addr_w, instr_pc_w;
  logic [34:0] rom_data_w, instr_w, dbg_data_w;
  logic        instr_valid_w, dbg_ack_w;
  logic [1:0]  state_w;

  logic [34:0] rom [256];
  assign rom_data   = rom[rom_addr];
  assign rom_data_w = rom[rom_addr_w];

  int n_cmp = 0;
  int n_mis = 0;

  fetch_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump_valid(jump_valid), .jump_target(jump_target),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_ack(dbg_ack), .state(state)
  );

  fetch_sequencer #(.RESET_PC(8'd252)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .rom_addr(rom_addr_w), .rom_data(rom_data_w),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(instr_ready), .jump_valid(jump_valid), .jump_target(jump_target),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data_w),
    .dbg_ack(dbg_ack_w), .state(state_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; halt = 0; instr_ready = 0; jump_valid = 0; jump_target = '0;
    dbg_req = 0; dbg_addr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if ({state, instr_valid, instr_pc, instr, dbg_ack, dbg_data} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got st=%0d v=%b pc=%h i=%h ack=%b d=%h want all 0",
               state, instr_valid, instr_pc, instr, dbg_ack, dbg_data);
    end
    n_cmp++;
    if (rom_addr !== 8'd0) begin
      n_mis++; $display("FAIL reset_rom_addr: got %h want 00", rom_addr);
    end
    n_cmp++;
    if ({state_w, rom_addr_w} !== {2'd0, 8'd252}) begin
      n_mis++; $display("FAIL reset_pc_252: got st=%0d addr=%h want 0/fc", state_w, rom_addr_w);
    end
    tick();
    rst_n = 1;
    instr_ready = 1;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({state, instr_valid} !== {2'd0, 1'b0}) begin
      n_mis++; $display("FAIL idle_without_start: got st=%0d v=%b want 0/0", state, instr_valid);
    end
    tick();
  endtask

  task automatic test_program();
    bit         exp_v [10] = '{0, 1, 1, 1, 0, 1, 1, 0, 1, 1};
    logic [7:0] exp_pc[10] = '{0, 0, 4, 8, 4, 4, 8, 4, 4, 8};
    bit         jmp   [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    do_reset();
    do_start();
    instr_ready = 1;
    jump_target = 8'd4;
    for (int i = 0; i < 10; i++) begin
      jump_valid = jmp[i];
      @(negedge clk);
      n_cmp++;
      if (instr_valid !== exp_v[i]) begin
        n_mis++; $display("FAIL prog_valid[%0d]: got %b want %b", i, instr_valid, exp_v[i]);
      end
      n_cmp++;
      if (exp_v[i] && {instr_pc, instr} !== {exp_pc[i], rom[exp_pc[i]]}) begin
        n_mis++; $display("FAIL prog_word[%0d]: got pc=%h i=%h want pc=%h", i, instr_pc, instr, exp_pc[i]);
      end else if (!exp_v[i] && rom_addr !== exp_pc[i]) begin
        n_mis++; $display("FAIL prog_fetch_addr[%0d]: got %h want %h", i, rom_addr, exp_pc[i]);
      end
      tick();
    end
    jump_valid = 0;
  endtask

  task automatic test_stall();
    do_reset();
    do_start();
    instr_ready = 1;
    tick();
    tick();
    instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, instr_pc, instr, rom_addr} !== {1'b1, 8'd4, rom[4], 8'd8}) begin
        n_mis++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h addr=%h want 1/04/08",
                          i, instr_valid, instr_pc, rom_addr);
      end
      tick();
    end
    instr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      e = 8'(4 + 4 * i);
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, e, rom[e]}) begin
        n_mis++; $display("FAIL stall_release[%0d]: got v=%b pc=%h want pc=%h", i, instr_valid, instr_pc, e);
      end
      tick();
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    do_start();
    instr_ready = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e;
      e = 8'd252 + 8'(4 * k);
      @(negedge clk);
      n_cmp++;
      if ({instr_valid_w, instr_pc_w, instr_w} !== {1'b1, e, rom[e]}) begin
        n_mis++; $display("FAIL pc_wrap[%0d]: got v=%b pc=%h want pc=%h", k, instr_valid_w, instr_pc_w, e);
      end
      tick();
    end
  endtask

  task automatic test_dbg_idle();
    do_reset();
    dbg_req = 1;
    dbg_addr = 8'd8;
    @(negedge clk);
    n_cmp++;
    if ({state, rom_addr} !== {2'd0, 8'd8}) begin
      n_mis++; $display("FAIL dbg_idle_grant: got st=%0d addr=%h want 0/08", state, rom_addr);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({dbg_ack, dbg_data, rom_addr} !== {1'b1, W_JMP, 8'd0}) begin
      n_mis++; $display("FAIL dbg_idle_ack: got ack=%b d=%h addr=%h want 1/%h/00", dbg_ack, dbg_data, rom_addr, W_JMP);
    end
    tick();
    dbg_req = 0;
    @(negedge clk);
    n_cmp++;
    if ({dbg_ack, dbg_data} !== {1'b0, W_JMP}) begin
      n_mis++; $display("FAIL dbg_ack_pulse: got ack=%b d=%h want 0/%h", dbg_ack, dbg_data, W_JMP);
    end
    tick();
  endtask

  task automatic test_dbg_halt();
    do_reset();
    do_start();
    instr_ready = 1;
    tick();
    halt = 1;
    instr_ready = 0;
    @(negedge clk);
    n_cmp++;
    if ({state, instr_valid, instr_pc} !== {2'd1, 1'b1, 8'd0}) begin
      n_mis++; $display("FAIL halt_entry: got st=%0d v=%b pc=%h want 1/1/00", state, instr_valid, instr_pc);
    end
    tick();
    dbg_req = 1;
    dbg_addr = 8'd8;
    @(negedge clk);
    n_cmp++;
    if ({state, rom_addr} !== {2'd2, 8'd8}) begin
      n_mis++; $display("FAIL dbg_halt_grant: got st=%0d addr=%h want 2/08", state, rom_addr);
    end
    tick();
    instr_ready = 1;
    @(negedge clk);
    n_cmp++;
    if ({dbg_ack, dbg_data, instr_valid, instr_pc, instr} !== {1'b1, rom[8], 1'b1, 8'd0, rom[0]}) begin
      n_mis++; $display("FAIL dbg_halt_ack: got ack=%b d=%h v=%b pc=%h i=%h", dbg_ack, dbg_data, instr_valid, instr_pc, instr);
    end
    tick();
    dbg_req = 0;
    halt = 0;
    @(negedge clk);
    n_cmp++;
    if ({state, instr_valid, dbg_ack} !== {2'd2, 1'b0, 1'b0}) begin
      n_mis++; $display("FAIL halt_consume: got st=%0d v=%b ack=%b want 2/0/0", state, instr_valid, dbg_ack);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({state, rom_addr} !== {2'd1, 8'd4}) begin
      n_mis++; $display("FAIL halt_resume: got st=%0d addr=%h want 1/04", state, rom_addr);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 8'd4, rom[4]}) begin
      n_mis++; $display("FAIL halt_resume_word: got v=%b pc=%h want 1/04", instr_valid, instr_pc);
    end
    tick();
  endtask

  task automatic test_starvation();
    bit         exp_v  [8] = '{1, 1, 1, 1, 1, 0, 1, 1};
    logic [7:0] exp_pc [8] = '{0, 4, 8, 12, 16, 0, 20, 24};
    do_reset();
    do_start();
    instr_ready = 1;
    dbg_addr = 8'd0;
    tick();
    for (int i = 0; i < 8; i++) begin
      dbg_req = (i < 6);
      @(negedge clk);
      n_cmp++;
      if (dbg_ack !== (i == 5)) begin
        n_mis++; $display("FAIL starve_ack[%0d]: got %b want %b", i, dbg_ack, (i == 5));
      end
      n_cmp++;
      if (instr_valid !== exp_v[i] || (exp_v[i] && {instr_pc, instr} !== {exp_pc[i], rom[exp_pc[i]]})) begin
        n_mis++; $display("FAIL starve_word[%0d]: got v=%b pc=%h want v=%b pc=%h", i, instr_valid, instr_pc, exp_v[i], exp_pc[i]);
      end
      if (i == 4) begin
        n_cmp++;
        if (rom_addr !== 8'd0) begin
          n_mis++; $display("FAIL starve_yield_addr: got %h want 00", rom_addr);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (dbg_data !== rom[0]) begin
          n_mis++; $display("FAIL starve_data: got %h want %h", dbg_data, rom[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_start();
    instr_ready = 1;
    tick();
    instr_ready = 0;
    dbg_req = 1;
    dbg_addr = 8'd8;
    rst_n = 0;
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, rom_addr} !== {1'b1, 8'd8}) begin
      n_mis++; $display("FAIL mid_pre: got v=%b addr=%h want 1/08", instr_valid, rom_addr);
    end
    tick();
    rst_n = 1;
    start = 1;
    @(negedge clk);
    n_cmp++;
    if ({state, instr_valid, instr_pc, instr, dbg_ack, dbg_data} !== '0) begin
      n_mis++; $display("FAIL mid_reset_outputs: got st=%0d v=%b pc=%h ack=%b d=%h want all 0",
                        state, instr_valid, instr_pc, dbg_ack, dbg_data);
    end
    tick();
    start = 0;
    instr_ready = 1;
    @(negedge clk);
    n_cmp++;
    if ({state, dbg_ack, dbg_data, rom_addr} !== {2'd1, 1'b1, rom[8], 8'd0}) begin
      n_mis++; $display("FAIL mid_represent: got st=%0d ack=%b d=%h addr=%h", state, dbg_ack, dbg_data, rom_addr);
    end
    tick();
    dbg_req = 0;
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 8'd0, rom[0]}) begin
      n_mis++; $display("FAIL mid_restart: got v=%b pc=%h want 1/00", instr_valid, instr_pc);
    end
    tick();
  endtask

  // Reference: accepted words appear in program order (step 4, restarting
  // at each jump target), each word matches the ROM at its address, every
  // debug read returns the ROM word within a bounded wait.
  task automatic test_random();
    logic [7:0] exp_next;
    logic [1:0] exp_state;
    bit         req_on, drop_next, xfer;
    int         req_wait, transfers, acks;
    do_reset();
    do_start();
    exp_next = 8'd0; exp_state = 2'd1;
    req_on = 0; drop_next = 0; req_wait = 0; transfers = 0; acks = 0;
    for (int c = 0; c < 3000; c++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      if (halt) halt = ($urandom_range(0, 9) >= 2);
      else      halt = ($urandom_range(0, 99) < 2);
      jump_valid = ($urandom_range(0, 99) < 5);
      jump_target = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {6'($urandom), 2'b00};
      if (drop_next) begin
        dbg_req = 0; req_on = 0; drop_next = 0;
      end else if (!req_on && $urandom_range(0, 9) == 0) begin
        dbg_req = 1; req_on = 1; req_wait = 0; dbg_addr = 8'($urandom);
      end
      @(negedge clk);
      n_cmp++;
      if (state !== exp_state) begin
        n_mis++; $display("FAIL rnd_state[%0d]: got %0d want %0d", c, state, exp_state);
      end
      xfer = (instr_valid === 1'b1) && instr_ready;
      if (xfer) begin
        transfers++;
        n_cmp++;
        if ({instr_pc, instr} !== {exp_next, rom[exp_next]}) begin
          n_mis++; $display("FAIL rnd_order[%0d]: got pc=%h i=%h want pc=%h i=%h", c, instr_pc, instr, exp_next, rom[exp_next]);
        end
      end
      if (dbg_ack === 1'b1) begin
        acks++;
        n_cmp++;
        if (!req_on || dbg_data !== rom[dbg_addr]) begin
          n_mis++; $display("FAIL rnd_dbg[%0d]: got req=%b d=%h want req=1 d=%h", c, req_on, dbg_data, rom[dbg_addr]);
        end
        drop_next = 1;
      end else if (req_on && !drop_next) begin
        req_wait++;
        if (req_wait > 20) begin
          n_cmp++; n_mis++;
          $display("FAIL rnd_dbg_timeout[%0d]: got no ack after %0d cycles want ack", c, req_wait);
          drop_next = 1;
        end
      end
      if (jump_valid) exp_next = jump_target;
      else if (xfer)  exp_next = exp_next + 8'd4;
      if (exp_state == 2'd1 && halt)       exp_state = 2'd2;
      else if (exp_state == 2'd2 && !halt) exp_state = 2'd1;
      tick();
    end
    clear_inputs();
    n_cmp++;
    if (transfers < 600) begin
      n_mis++; $display("FAIL rnd_throughput: got %0d transfers want >= 600", transfers);
    end
    n_cmp++;
    if (acks < 50) begin
      n_mis++; $display("FAIL rnd_dbg_count: got %0d acks want >= 50", acks);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {3'($urandom), 32'($urandom)};
    rom[0] = W_MOV;
    rom[4] = W_ACC;
    rom[8] = W_JMP;
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_program();
    test_stall();
    test_pc_wrap();
    test_dbg_idle();
    test_dbg_halt();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the CPU program ROM (asynchronous, 8-bit address, 35-bit instruction word).
- Owns the program counter, drives the ROM address and fetches one instruction per cycle into a registered output buffer.
- Hands instructions to decode over a valid/ready handshake and redirects on jumps from execute.
- Shares the ROM read port with a debug/inspection requester through an arbiter with a starvation guard.

Parameters:
RESET_PC, 8'd0, PC value loaded on reset.
PC_STEP, 8'd4, PC increment per sequential fetch; program words sit at multiples of 4.
DBG_MAX_WAIT, 4, consecutive ungranted debug-request cycles before a fetch cycle is forcibly yielded (1..15).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
start  in  1  pulse; leaves IDLE and begins fetching.
halt  in  1  level; stops new fetches while high.
rom_addr  out  8  combinational address to the program ROM.
rom_data  in  35  combinational ROM data for rom_addr.
instr  out  35  buffered instruction word.
instr_pc  out  8  address instr was fetched from.
instr_valid  out  1  instr/instr_pc hold an unconsumed instruction.
instr_ready  in  1  decode accepts; transfer when instr_valid && instr_ready.
jump_valid  in  1  single-cycle redirect request from execute.
jump_target  in  8  redirect address.
dbg_req  in  1  debug read request; held high until dbg_ack.
dbg_addr  in  8  debug read address; stable while dbg_req is high.
dbg_data  out  35  debug read result; valid when dbg_ack is high.
dbg_ack  out  1  one-cycle pulse completing a debug read.
state  out  2  0 = IDLE, 1 = RUN, 2 = HALT.

Behaviour:
- Reset (rst_n low at an edge, any state, mid-operation included):
  - pc = RESET_PC; state = IDLE.
  - instr, instr_pc, instr_valid, dbg_data, dbg_ack and wait counter all 0.
  - Any pending debug grant is dropped; the requester re-presents it.
- States:
  - IDLE -> RUN on start.
  - RUN -> HALT when halt = 1.
  - HALT -> RUN when halt = 0.
  - start is ignored outside IDLE.
- Buffer free: !instr_valid || instr_ready.
- Fetch cycle: state = RUN, halt = 0, jump_valid = 0, buffer free, no forced yield.
  - rom_addr = pc.
  - Next edge: instr <= rom_data, instr_pc <= pc, instr_valid <= 1, pc <= pc + PC_STEP (mod 256; 252 + 4 wraps to 0).
  - Latency from pc to instr_valid is 1 cycle. Sustained throughput is 1 instruction/cycle with ready held high.
- Consume without fetch: instr_valid <= 0.
- Stall: instr_valid && !instr_ready holds instr, instr_pc and pc unchanged.
- Jump (any state except IDLE):
  - Next edge: pc <= jump_target and instr_valid <= 0, flushing the buffered word even if it was consumed the same cycle.
  - No fetch occurs in the jump cycle. The target instruction becomes valid 2 edges after the jump cycle.
  - Jump beats halt and debug in the same cycle. jump_target is used unaligned as-is.
- HALT: the buffered instruction remains valid and can still be consumed; no new fetch.
- Debug arbitration:
  - Grant when dbg_req && !dbg_ack and the ROM is not used for fetch that cycle (IDLE, HALT, stall, jump cycle, or forced yield).
  - Granted cycle: rom_addr = dbg_addr. Next edge: dbg_data <= rom_data, dbg_ack <= 1 for exactly one cycle.
  - At most one grant per request; no grant in the ack cycle.
  - dbg_data holds its value until the next grant.
- Starvation guard:
  - A 4-bit counter increments each cycle dbg_req is high and ungranted; it clears on grant or when dbg_req is low.
  - When the counter equals DBG_MAX_WAIT, the next eligible fetch cycle becomes a forced yield (debug granted, pc untouched).
- rom_addr when neither fetch nor debug is active: pc.

Test Plan:
- ROM program: 0 MOV 0->DOUT, 4 ACC DOUT+=15, 8 JMP 4. Reset, start, instr_ready = 1 -> instr_pc sequence 0, 4, 8; jump_valid pulsed with target 4 on the cycle addr 8 is accepted -> 1 bubble, then 4, 8, 4, 8… with no stray word from addr 12.
- instr_ready low 3 cycles while instr_pc = 4 -> instr and instr_pc held, pc stays 8; release -> addr 8 next cycle, no skip or duplicate.
- RESET_PC = 252, sequential run -> instr_pc 252 then 0.
- dbg_req addr 8 while in IDLE -> dbg_ack 1 cycle later with dbg_data = JMP word; dbg_req in HALT with buffered word intact -> ack, buffer unchanged.
- Continuous fetch with ready = 1 and dbg_req addr 0 -> ack on the cycle after DBG_MAX_WAIT ungranted cycles; exactly one fetch slot lost; instr_pc order preserved.
- rst_n low for one edge mid-stall with dbg_req pending -> all outputs 0, state IDLE, no dbg_ack; after start, fetch resumes at RESET_PC.
